// File: rtl/dotp_pkg.sv
// Shared types and defaults for the dot-product MAC unit.
package dotp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWrite,
    StDone
  } dotp_state_e;

  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefBitsComp  = 4;
  localparam int unsigned DefAccWidth  = 16;

  // Largest unsigned value representable in `width` bits (capped at 32 bits).
  function automatic logic [31:0] ACC_MAX(input int unsigned width);
    if (width >= 32) begin
      ACC_MAX = 32'hffff_ffff;
    end else begin
      ACC_MAX = (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/dotp_mul_stage.sv
// Registered unsigned multiplier with valid bit; first pipeline stage of the MAC.
module dotp_mul_stage #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [DataWidth-1:0]   a_i,
  input  logic [DataWidth-1:0]   b_i,
  output logic [2*DataWidth-1:0] prod_o,
  output logic                   prod_v_o
);

  logic [2*DataWidth-1:0] prod_q, prod_d;
  logic                   prod_v_q, prod_v_d;

  always_comb begin
    prod_d   = prod_q;
    prod_v_d = en_i & ~clr_i;
    if (en_i) begin
      prod_d = {{DataWidth{1'b0}}, a_i} * {{DataWidth{1'b0}}, b_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

  assign prod_o   = prod_q;
  assign prod_v_o = prod_v_q;

endmodule

// File: rtl/dotp_mac_unit.sv
// Dot-product MAC: multiplies SRAM A/B operand pairs, accumulates Nums_Computation products
// and writes the sum to the result SRAM. Define DOTP_SATURATE_EN for saturating accumulation.
module dotp_mac_unit
  import dotp_pkg::*;
#(
  parameter int unsigned Addr_Width       = DefAddrWidth,
  parameter int unsigned Data_Width       = DefDataWidth,
  parameter int unsigned bits_Computation = DefBitsComp,
  parameter int unsigned Nums_Computation = 1 << bits_Computation,
  parameter int unsigned Acc_Width        = DefAccWidth
) (
  input  logic                      clk,
  input  logic                      Comp_reset,
  input  logic                      Computing,
  input  logic                      En_Read_A,
  input  logic                      En_Read_B,
  input  logic [Data_Width-1:0]     Data_A,
  input  logic [Data_Width-1:0]     Data_B,
  input  logic [Addr_Width-1:0]     Result_Addr,
  output logic                      Wr_En,
  output logic [Addr_Width-1:0]     Wr_Addr,
  output logic [Acc_Width-1:0]      Wr_Data,
  output logic [Acc_Width-1:0]      Result,
  output logic                      Done,
  output logic                      Busy,
  output logic [bits_Computation:0] Count
);

  localparam logic [bits_Computation:0] CountMax = (bits_Computation + 1)'(Nums_Computation);
  localparam logic [bits_Computation:0] CountOne = (bits_Computation + 1)'(1);

  dotp_state_e state_q, state_d;

  logic                      rd_v;
  logic                      rd_v_d1_q, rd_v_d1_d;
  logic [2*Data_Width-1:0]   prod;
  logic                      prod_v;
  logic                      run_start;
  logic                      acc_en;
  logic [Acc_Width-1:0]      acc_q, acc_d, acc_next;
  logic [bits_Computation:0] count_q, count_d;
  logic                      wr_en_q, wr_en_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic [Addr_Width-1:0]     wr_addr_q, wr_addr_d;
  logic [Acc_Width-1:0]      wr_data_q, wr_data_d;
  logic [Acc_Width-1:0]      result_q, result_d;

  assign rd_v      = En_Read_A & En_Read_B;
  assign run_start = (state_q == StIdle) && Computing;
  assign acc_en    = (state_q == StRun) && prod_v;

  dotp_mul_stage #(
    .DataWidth (Data_Width)
  ) u_mul (
    .clk_i    (clk),
    .rst_i    (Comp_reset),
    .clr_i    (run_start),
    .en_i     (rd_v_d1_q),
    .a_i      (Data_A),
    .b_i      (Data_B),
    .prod_o   (prod),
    .prod_v_o (prod_v)
  );

`ifdef DOTP_SATURATE_EN
  localparam logic [Acc_Width-1:0] AccMax = Acc_Width'(ACC_MAX(Acc_Width));

  logic             ovf_q, ovf_d;
  logic [Acc_Width:0] sum;

  // Once the sticky flag is set the accumulator is pinned at the maximum.
  always_comb begin
    sum      = {1'b0, acc_q} + (Acc_Width + 1)'(prod);
    acc_next = (ovf_q || sum[Acc_Width]) ? AccMax : sum[Acc_Width-1:0];
    ovf_d    = ovf_q;
    if (run_start) begin
      ovf_d = 1'b0;
    end else if (acc_en) begin
      ovf_d = ovf_q | sum[Acc_Width];
    end
  end

  always_ff @(posedge clk or posedge Comp_reset) begin
    if (Comp_reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  always_comb begin
    acc_next = acc_q + Acc_Width'(prod);
  end
`endif

  always_comb begin
    state_d   = state_q;
    rd_v_d1_d = 1'b0;
    acc_d     = acc_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (Computing) begin
          state_d = StRun;
          acc_d   = '0;
          count_d = '0;
        end
      end
      StRun: begin
        rd_v_d1_d = rd_v;
        if (acc_en) begin
          acc_d   = acc_next;
          count_d = count_q + CountOne;
        end
        // Completion wins over a simultaneous abort.
        if (count_d == CountMax) begin
          state_d = StWrite;
        end else if (!Computing) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        wr_en_d   = 1'b1;
        wr_addr_d = Result_Addr;
        wr_data_d = acc_q;
        result_d  = acc_q;
        state_d   = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge Comp_reset) begin
    if (Comp_reset) begin
      state_q   <= StIdle;
      rd_v_d1_q <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_v_d1_q <= rd_v_d1_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      result_q  <= result_d;
    end
  end

  assign Wr_En   = wr_en_q;
  assign Wr_Addr = wr_addr_q;
  assign Wr_Data = wr_data_q;
  assign Result  = result_q;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign Count   = count_q;

endmodule
